// File: rtl/clk_divider_prog.sv
// ---------------------------------------------------------------------------
// clk_divider_prog
//   Runtime-programmable clock divider. Produces a registered divided clock
//   whose period is N input-clock cycles (any N >= 2). The high phase covers
//   phases 0..floor(N/2)-1, so odd divisors are high for the shorter half.
//   A new divisor is requested with a load strobe, held pending, and swapped
//   in only at a period boundary, so the output never glitches. A run enable
//   stops the divider cleanly at the end of the current period, and a
//   one-cycle tick marks the first cycle of each period for use as a clock
//   enable downstream.
//
// Ports
//   i_clk       system clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_en        run request (level)
//   i_div_val   new divisor, sampled with i_div_load
//   i_div_load  single-cycle load request
//   o_clk       divided clock (registered)
//   o_tick      1 on phase 0 of every running period
//   o_running   1 while the divider is running
//   o_div_pend  a legal divisor is waiting to be applied
//   o_div_ack   1-cycle pulse when the pending divisor becomes active
//   o_div_err   1-cycle pulse when a load is rejected (value < 2)
//   o_div_cur   divisor currently in effect
//   o_cnt_val   phase index within the current period
// ---------------------------------------------------------------------------
module clk_divider_prog #(
    parameter int CNT_W   = 16,
    parameter int DIV_RST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div_val,
    input  logic             i_div_load,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_running,
    output logic             o_div_pend,
    output logic             o_div_ack,
    output logic             o_div_err,
    output logic [CNT_W-1:0] o_div_cur,
    output logic [CNT_W-1:0] o_cnt_val
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] div_cur_q,  div_cur_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q,     pend_d;
    logic             clk_q,      clk_d;
    logic             tick_q,     tick_d;
    logic             ack_q,      ack_d;
    logic             err_q,      err_d;

    logic last_phase;
    logic apply;

    // The counter never passes N-1, so comparing against N-1 cannot wrap.
    assign last_phase = (state_q == ST_RUN) && (cnt_q == div_cur_q - ONE);

    // A pending divisor goes live at a running period boundary, or on the
    // very next edge while idle (there is no period to protect then).
    assign apply = pend_q && ((state_q == ST_IDLE) || last_phase);

    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // i_en only matters at the boundary, so a mid-period drop
                // still lets the low phase finish.
                if (last_phase) begin
                    cnt_d = '0;
                    if (!i_en) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loads are only considered with nothing pending, which also keeps
        // ack and err from ever pulsing together.
        if (apply) begin
            div_cur_d = pend_val_q;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
        end else if (i_div_load && !pend_q) begin
            if (i_div_val < TWO) begin
                err_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_val_d = i_div_val;
            end
        end

        // Outputs are decoded from next-state values so they are registered
        // yet line up with the phase index of the same cycle.
        clk_d  = (state_d == ST_RUN) && (cnt_d < (div_cur_d >> 1));
        tick_d = (state_d == ST_RUN) && (cnt_d == '0);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_cur_q  <= DIV_RST_V;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign o_clk      = clk_q;
    assign o_tick     = tick_q;
    assign o_running  = (state_q == ST_RUN);
    assign o_div_pend = pend_q;
    assign o_div_ack  = ack_q;
    assign o_div_err  = err_q;
    assign o_div_cur  = div_cur_q;
    assign o_cnt_val  = cnt_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_prog
//   Scoreboard bench for clk_divider_prog. The stimulus process drives one
//   cycle of inputs, advances a behavioural model of the divider and queues
//   the expected outputs; a monitor pops and compares on every falling edge.
//   An 8-bit instance keeps the full-scale divisor (255) cheap to run.
// ---------------------------------------------------------------------------
module tb_clk_divider_prog;

    localparam int CNT_W   = 8;
    localparam int DIV_RST = 4;
    localparam int N_MAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             clk;
        logic             tick;
        logic             running;
        logic             pend;
        logic             ack;
        logic             err;
        logic [CNT_W-1:0] cur;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             o_clk, o_tick, o_running, o_div_pend, o_div_ack, o_div_err;
    logic [CNT_W-1:0] o_div_cur, o_cnt_val;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Model state: running flag, phase k, period n, pending request.
    bit m_run  = 1'b0;
    int m_k    = 0;
    int m_n    = DIV_RST;
    bit m_pend = 1'b0;
    int m_pval = 0;
    bit m_ack  = 1'b0;
    bit m_err  = 1'b0;

    always #5 clk = ~clk;

    clk_divider_prog #(
        .CNT_W  (CNT_W),
        .DIV_RST(DIV_RST)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_div_val (div_val),
        .i_div_load(div_load),
        .o_clk     (o_clk),
        .o_tick    (o_tick),
        .o_running (o_running),
        .o_div_pend(o_div_pend),
        .o_div_ack (o_div_ack),
        .o_div_err (o_div_err),
        .o_div_cur (o_div_cur),
        .o_cnt_val (o_cnt_val)
    );

    // Advance the model by one clock edge given this cycle's inputs.
    function automatic void model_step(input bit r, input bit e, input bit ld, input int val);
        bit at_end;
        bit take;
        bit was_pend;
        if (r) begin
            m_run = 0; m_k = 0; m_n = DIV_RST;
            m_pend = 0; m_pval = 0; m_ack = 0; m_err = 0;
            return;
        end
        at_end   = m_run && ((m_k + 1) % m_n == 0);
        take     = m_pend && (!m_run || at_end);
        was_pend = m_pend;
        m_ack = 0;
        m_err = 0;
        if (m_run) begin
            if (at_end) begin
                m_k   = 0;
                m_run = e;
            end else begin
                m_k = m_k + 1;
            end
        end else if (e) begin
            m_run = 1;
            m_k   = 0;
        end
        if (take) begin
            m_n = m_pval; m_pend = 0; m_ack = 1;
        end else if (ld && !was_pend) begin
            if (val < 2) m_err = 1;
            else begin m_pend = 1; m_pval = val; end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.clk     = m_run && (m_k < m_n / 2);
        o.tick    = m_run && (m_k == 0);
        o.running = m_run;
        o.pend    = m_pend;
        o.ack     = m_ack;
        o.err     = m_err;
        o.cur     = CNT_W'(m_n);
        o.cnt     = CNT_W'(m_k);
        return o;
    endfunction

    task automatic step(input bit r, input bit e, input bit ld, input int val);
        rst      = r;
        en       = e;
        div_load = ld;
        div_val  = CNT_W'(val);
        model_step(r, e, ld, val);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 1, 0, 0);
    endtask

    // Keep running until the model reaches phase k; bounded.
    task automatic run_to_k(input int k);
        int budget;
        budget = 2 * N_MAX + 4;
        while (!(m_run && m_k == k) && budget > 0) begin
            step(0, 1, 0, 0);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_to_k: phase %0d not reached (model k=%0d n=%0d)", k, m_k, m_n);
        end
    endtask

    // Monitor: one comparison per cycle against the queued expectation.
    always @(negedge clk) begin
        obs_t exp_o;
        obs_t act_o;
        cyc++;
        if (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            act_o = '{o_clk, o_tick, o_running, o_div_pend, o_div_ack, o_div_err,
                      o_div_cur, o_cnt_val};
            n_cmp++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL outputs @cyc %0d: got clk=%b tick=%b run=%b pend=%b ack=%b err=%b cur=%0d k=%0d, expected clk=%b tick=%b run=%b pend=%b ack=%b err=%b cur=%0d k=%0d",
                         cyc, act_o.clk, act_o.tick, act_o.running, act_o.pend, act_o.ack,
                         act_o.err, act_o.cur, act_o.cnt, exp_o.clk, exp_o.tick,
                         exp_o.running, exp_o.pend, exp_o.ack, exp_o.err, exp_o.cur, exp_o.cnt);
            end
        end
    end

    initial begin
        // Reset with enable low, then run at the reset divisor (1100...).
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        run(12);

        // Load 5 mid-period; applied at the next boundary (11000).
        run_to_k(1);
        step(0, 1, 1, 5);
        run(14);

        // Two illegal loads: error pulses, no other effect.
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        run(3);

        // N=6, drop enable at k=1: period completes, then idle, then restart.
        step(0, 1, 1, 6);
        run(12);
        run_to_k(1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        run(8);

        // Load 3 in the boundary cycle, then 7 while pending (ignored).
        run_to_k(5);
        step(0, 1, 1, 3);
        step(0, 1, 1, 7);
        run(16);

        // N=8 run, load pending at k=2, reset lands on that cycle.
        step(0, 1, 1, 8);
        run(6);
        run_to_k(1);
        step(0, 1, 1, 9);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Load while idle applies on the next edge; then N=2 toggling.
        step(0, 0, 1, 2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        run(10);

        // Full-scale divisor: two complete periods without overflow.
        step(0, 1, 1, N_MAX);
        run(2 * N_MAX + 8);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r_e;
            bit r_ld;
            bit r_rst;
            int r_v;
            r_e   = ($urandom_range(0, 9) != 0);
            r_ld  = ($urandom_range(0, 6) == 0);
            r_rst = ($urandom_range(0, 499) == 0);
            r_v   = ($urandom_range(0, 40) == 0) ? N_MAX : int'($urandom_range(0, 13));
            step(r_rst, r_e, r_ld, r_v);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
